// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller for a short in-order pipe.
// Detects load-use hazards and taken branches. Drives the PC and pipeline
// register enables, and the flush controls. HALT holds the pipe until resume.
// All outputs are registered Moore outputs decoded from the next state.
// Optional feature: define PIPE_STALL_COUNTER_EN to count STALL/HALT cycles
// in stall_count, which saturates at 8'hFF. Without it, stall_count is 0.
//
// Handshake note: there is no valid/ready pair on this block. branch_taken
// and resume are single-cycle level inputs sampled at the rising edge. resume
// is only honoured while the block is in HALT.
module pipe_hazard_ctrl #(
  parameter int         FLUSH_LEN = 2,        // legal 1..7
  parameter logic [2:0] OP_LOAD   = 3'b011,
  parameter logic [2:0] OP_HALT   = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] id_op,
  input  logic [2:0] id_a,
  input  logic [2:0] id_b,
  input  logic [2:0] ex_op,
  input  logic [2:0] ex_a,
  input  logic       branch_taken,
  input  logic       resume,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] state,
  output logic [7:0] stall_count
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pc_en_q, pc_en_d;
  logic       ifid_en_q, ifid_en_d;
  logic       idex_en_q, idex_en_d;
  logic       ifid_flush_q, ifid_flush_d;
  logic       idex_flush_q, idex_flush_d;
  logic       load_use;

  // A load in EX whose destination feeds either decode source.
  assign load_use = (ex_op == OP_LOAD) && ((ex_a == id_a) || (ex_a == id_b));

  // Next-state and flush-counter logic. Branches only count from RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (load_use) begin
          state_d = ST_STALL;
        end else if (id_op == OP_HALT) begin
          state_d = ST_HALT;
        end
      end
      ST_STALL: state_d = ST_RUN;
      ST_FLUSH: begin
        if (cnt_q == 3'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode from the next state. Only these four combinations exist.
  always_comb begin
    pc_en_d      = 1'b1;
    ifid_en_d    = 1'b1;
    idex_en_d    = 1'b1;
    ifid_flush_d = 1'b0;
    idex_flush_d = 1'b0;
    case (state_d)
      ST_STALL: begin
        pc_en_d      = 1'b0;
        ifid_en_d    = 1'b0;
        idex_flush_d = 1'b1;
      end
      ST_FLUSH: begin
        ifid_flush_d = 1'b1;
        idex_flush_d = 1'b1;
      end
      ST_HALT: begin
        pc_en_d   = 1'b0;
        ifid_en_d = 1'b0;
        idex_en_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State, counter and output registers; reset returns to RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= 3'd0;
      pc_en_q      <= 1'b1;
      ifid_en_q    <= 1'b1;
      idex_en_q    <= 1'b1;
      ifid_flush_q <= 1'b0;
      idex_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_en_q      <= pc_en_d;
      ifid_en_q    <= ifid_en_d;
      idex_en_q    <= idex_en_d;
      ifid_flush_q <= ifid_flush_d;
      idex_flush_q <= idex_flush_d;
    end
  end

  assign state      = state_q;
  assign pc_en      = pc_en_q;
  assign ifid_en    = ifid_en_q;
  assign idex_en    = idex_en_q;
  assign ifid_flush = ifid_flush_q;
  assign idex_flush = idex_flush_q;

`ifdef PIPE_STALL_COUNTER_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Count each cycle that the registered state is STALL or HALT. Stop at 8'hFF.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_d == ST_STALL) || (state_d == ST_HALT)) && (stall_cnt_q != 8'hFF))
      stall_cnt_d = stall_cnt_q + 8'd1;
  end

  // Stall counter register.
  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= 8'h00;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 8'h00;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl. The bench uses
// the default parameters. Define PIPE_STALL_COUNTER_EN to also check the
// stall counter.
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] id_op = 3'd0, id_a = 3'd0, id_b = 3'd0;
  logic [2:0] ex_op = 3'd0, ex_a = 3'd0;
  logic       branch_taken = 1'b0, resume = 1'b0;
  logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush;
  logic [1:0] state;
  logic [7:0] stall_count;

  int   n_tests  = 0;
  int   n_failed = 0;
  logic [7:0] exp_sc = 8'h00;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  pipe_hazard_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .id_op        (id_op),
    .id_a         (id_a),
    .id_b         (id_b),
    .ex_op        (ex_op),
    .ex_a         (ex_a),
    .branch_taken (branch_taken),
    .resume       (resume),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state        (state),
    .stall_count  (stall_count)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Expected {pc_en, ifid_en, idex_en, ifid_flush, idex_flush} for each state.
  function automatic logic [4:0] exp_outs(input logic [1:0] st);
    case (st)
      ST_RUN:   return 5'b11100;
      ST_STALL: return 5'b00101;
      ST_FLUSH: return 5'b11111;
      default:  return 5'b00000;
    endcase
  endfunction

  // Check every output against the expected state and the stall model.
  task automatic check_all(input string tag, input logic [1:0] st);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".outs"}, 32'({pc_en, ifid_en, idex_en, ifid_flush, idex_flush}),
          32'(exp_outs(st)));
    check({tag, ".stall_count"}, 32'(stall_count), 32'(exp_sc));
  endtask

  // ---------------- driver ----------------
  // Advance one clock. Update the stall model for the state that should now be
  // registered. Inputs change 1 time unit after the edge.
  task automatic tick(input logic [1:0] st);
    @(posedge clock);
    #1;
`ifdef PIPE_STALL_COUNTER_EN
    if (reset) exp_sc = 8'h00;
    else if (((st == ST_STALL) || (st == ST_HALT)) && exp_sc != 8'hFF) exp_sc = exp_sc + 8'd1;
`endif
  endtask

  task automatic step(input string tag, input logic [1:0] st);
    tick(st);
    check_all(tag, st);
  endtask

  task automatic clear_inputs();
    id_op = 3'd0; id_a = 3'd0; id_b = 3'd0;
    ex_op = 3'd0; ex_a = 3'd0;
    branch_taken = 1'b0; resume = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    reset = 1'b1;
    step("reset", ST_RUN);
    reset = 1'b0;
    step("idle", ST_RUN);

    // Load-use through id_a
    ex_op = 3'b011; ex_a = 3'd2; id_a = 3'd2; id_b = 3'd0;
    step("lu_a", ST_STALL);
    clear_inputs();
    step("lu_a_back", ST_RUN);

    // Load-use through id_b
    ex_op = 3'b011; ex_a = 3'd5; id_a = 3'd1; id_b = 3'd5;
    step("lu_b", ST_STALL);
    clear_inputs();
    step("lu_b_back", ST_RUN);

    // A load with no register match is not a hazard
    ex_op = 3'b011; ex_a = 3'd3; id_a = 3'd2; id_b = 3'd1;
    step("lu_nomatch", ST_RUN);
    // A matching register with a non-load op is not a hazard
    ex_op = 3'b010; ex_a = 3'd2; id_a = 3'd2;
    step("nonload_match", ST_RUN);
    clear_inputs();

    // Branch: two flush cycles. branch_taken held high does not extend them.
    branch_taken = 1'b1;
    step("br_f1", ST_FLUSH);
    step("br_f2", ST_FLUSH);
    step("br_exit", ST_RUN);
    branch_taken = 1'b0;
    step("br_run", ST_RUN);

    // Priority: branch wins over load-use and halt
    branch_taken = 1'b1; ex_op = 3'b011; ex_a = 3'd4; id_a = 3'd4; id_op = 3'b111;
    step("prio_f1", ST_FLUSH);
    branch_taken = 1'b0;
    step("prio_f2", ST_FLUSH);
    // Hazard seen in the last FLUSH cycle is acted on only after RUN
    step("prio_exit", ST_RUN);
    step("prio_stall", ST_STALL);
    ex_op = 3'd0;
    step("prio_back", ST_RUN);

    // Halt (id_op still 111): five HALT cycles, then resume
    step("halt_1", ST_HALT);
    id_op = 3'd0;
    for (int i = 2; i <= 5; i++) step($sformatf("halt_%0d", i), ST_HALT);
    resume = 1'b1;
    step("resume", ST_RUN);
    // resume is ignored outside HALT
    step("resume_in_run", ST_RUN);
    resume = 1'b0;
    step("post_resume", ST_RUN);

    // Reset in the first FLUSH cycle
    branch_taken = 1'b1;
    step("rst_f1", ST_FLUSH);
    branch_taken = 1'b0;
    reset = 1'b1;
    step("rst_mid_flush", ST_RUN);
    reset = 1'b0;
    step("rst_after", ST_RUN);

    // Hold HALT for 300 cycles: the counter saturates and does not wrap
    id_op = 3'b111;
    tick(ST_HALT);
    id_op = 3'd0;
    for (int i = 1; i < 300; i++) tick(ST_HALT);
    check_all("halt_300", ST_HALT);
`ifdef PIPE_STALL_COUNTER_EN
    check("sat_ff", 32'(stall_count), 32'h0000_00FF);
`endif
    resume = 1'b1;
    step("sat_resume", ST_RUN);
    resume = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    n_tests++;
    n_failed++;
    $display("FAIL timeout: got no end of stimulus, required finish before 100000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
